// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system-bus master port:
//   - state_t             : controller state encoding
//   - MODE_READ/MODE_WRITE: transaction direction encoding (d_mode / m_mode)
//   - BIT_ORDER_LSB_FIRST : serial bit order used on the bus
//   - bit_cnt_width()     : width of the phase bit counter
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_WDATA    = 3'd4,
    ST_RDATA    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Serial words travel least-significant bit first.
  localparam bit BIT_ORDER_LSB_FIRST = 1'b1;

  // Counter must be able to hold the full phase length (not just length-1),
  // because "all bits sent" is detected as count == length.
  function automatic int bit_cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/serial_master_port_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter
// Load / shift-out / shift-in register with a bit counter, used for both the
// address phase and the data phase of the serial master port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : load load_data_i and clear the bit counter
//   load_data_i     : parallel word to send
//   shift_out_i     : advance one bit (out_bit_o is the bit being consumed)
//   shift_in_i      : shift in_bit_i into the word and advance one bit
//   in_bit_i        : serial input bit
//   word_next_o     : register contents after this cycle's update
//   out_bit_o       : next bit to be sent
//   last_o          : counter is at WIDTH-1 (this shift completes the word)
//   done_o          : counter reached WIDTH (whole word handled)
// -----------------------------------------------------------------------------
module serial_shifter
  import bus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter bit LSB_FIRST = BIT_ORDER_LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_out_i,
  input  logic             shift_in_i,
  input  logic             in_bit_i,
  output logic [WIDTH-1:0] word_next_o,
  output logic             out_bit_o,
  output logic             last_o,
  output logic             done_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_bit;

  // Shift-out fills with 0; shift-in fills with the received bit, entering at
  // the far end so that after WIDTH shifts the first bit sits in its home slot.
  assign fill_bit = shift_in_i ? in_bit_i : 1'b0;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_out_i || shift_in_i) begin
      if (LSB_FIRST) word_d = {fill_bit, word_q[WIDTH-1:1]};
      else           word_d = {word_q[WIDTH-2:0], fill_bit};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_next_o = word_d;
  assign out_bit_o   = LSB_FIRST ? word_q[0] : word_q[WIDTH-1];
  assign last_o      = (cnt_q == CNT_W'(WIDTH - 1));
  assign done_o      = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: rtl/serial_master_port.sv
// -----------------------------------------------------------------------------
// serial_master_port
// Converts one parallel device transaction into the serial system-bus
// protocol: arbiter request/grant, serial address (LSB first), slave
// acknowledge, then serial write data or serial read data. One transaction
// outstanding at a time; all outputs registered.
// Optional build macro: SERIAL_MASTER_PORT_TIMEOUT_EN -- bounds the wait for
//   s_ack to TIMEOUT_CYCLES cycles and pulses d_err on expiry. Without it the
//   acknowledge wait is unbounded and d_err is constant 0.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   d_valid/d_ready              : device request handshake (ready only in IDLE)
//   d_mode, d_addr, d_wdata      : device request (0 = read, 1 = write)
//   d_rdata                      : last completed read word
//   d_err                        : one-cycle pulse on an aborted transaction
//   b_req/b_grant                : arbiter request / grant
//   m_mode, m_wvalid, m_wdata    : serial master outputs
//   s_ack, s_rvalid, s_rdata     : slave acknowledge and serial read data
// -----------------------------------------------------------------------------
module serial_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  input  logic                  d_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  b_req,
  input  logic                  b_grant,
  output logic                  m_mode,
  output logic                  m_wvalid,
  output logic                  m_wdata,
  input  logic                  s_ack,
  input  logic                  s_rvalid,
  input  logic                  s_rdata
);

  localparam int CNT_W = bit_cnt_width(ADDR_WIDTH, DATA_WIDTH);

  state_t                state_q;
  logic                  mode_q;
  logic                  d_ready_q, b_req_q, m_mode_q, m_wvalid_q, m_wdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  logic                  accept;
  logic                  a_shift, d_shift_out, d_shift_in;
  logic                  a_bit, a_done, a_last;
  logic                  d_bit, d_done, d_last;
  logic [ADDR_WIDTH-1:0] a_word_next;
  logic [DATA_WIDTH-1:0] d_word_next;

  // d_ready_q is high exactly in IDLE, so this is the accept handshake.
  assign accept = d_valid && d_ready_q;

  // Shifter strobes: each shift happens on the edge that also registers the
  // bit onto m_wdata, so m_wdata always shows the bit consumed last edge.
  always_comb begin
    a_shift     = 1'b0;
    d_shift_out = 1'b0;
    d_shift_in  = 1'b0;
    case (state_q)
      ST_REQ:      a_shift     = b_grant;
      ST_ADDR:     a_shift     = !a_done;
      ST_ACK_WAIT: d_shift_out = s_ack && (mode_q == MODE_WRITE);
      ST_WDATA:    d_shift_out = !d_done;
      ST_RDATA:    d_shift_in  = s_rvalid;
      default:     ;
    endcase
  end

  serial_shifter #(.WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_addr_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_data_i (d_addr),
    .shift_out_i (a_shift),
    .shift_in_i  (1'b0),
    .in_bit_i    (1'b0),
    .word_next_o (a_word_next),
    .out_bit_o   (a_bit),
    .last_o      (a_last),
    .done_o      (a_done)
  );

  serial_shifter #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_data_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_data_i (d_wdata),
    .shift_out_i (d_shift_out),
    .shift_in_i  (d_shift_in),
    .in_bit_i    (s_rdata),
    .word_next_o (d_word_next),
    .out_bit_o   (d_bit),
    .last_o      (d_last),
    .done_o      (d_done)
  );

  // The address shifter only sends; its parallel view and last flag are spare.
  logic unused_addr_shifter;
  assign unused_addr_shifter = ^{a_word_next, a_last};

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             d_err_q;
  assign d_err = d_err_q;
`else
  assign d_err = 1'b0;
  // Keeps the parameter referenced when the timeout logic is compiled out.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_READ;
      d_ready_q  <= 1'b1;
      d_rdata_q  <= '0;
      b_req_q    <= 1'b0;
      m_mode_q   <= 1'b0;
      m_wvalid_q <= 1'b0;
      m_wdata_q  <= 1'b0;
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
      tmo_q      <= '0;
      d_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_q    <= d_mode;
            d_ready_q <= 1'b0;
            b_req_q   <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (b_grant) begin
            state_q    <= ST_ADDR;
            m_mode_q   <= mode_q;
            m_wvalid_q <= 1'b1;
            m_wdata_q  <= a_bit;
          end
        end
        ST_ADDR: begin
          if (a_done) begin
            state_q    <= ST_ACK_WAIT;
            m_wvalid_q <= 1'b0;
            m_wdata_q  <= 1'b0;
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end else begin
            m_wdata_q <= a_bit;
          end
        end
        ST_ACK_WAIT: begin
          // An acknowledge on the expiry cycle takes priority over the timeout.
          if (s_ack) begin
            if (mode_q == MODE_READ) begin
              state_q <= ST_RDATA;
            end else begin
              state_q    <= ST_WDATA;
              m_wvalid_q <= 1'b1;
              m_wdata_q  <= d_bit;
            end
          end
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_DONE;
            b_req_q <= 1'b0;
            d_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        ST_WDATA: begin
          if (d_done) begin
            state_q    <= ST_DONE;
            b_req_q    <= 1'b0;
            m_wvalid_q <= 1'b0;
            m_wdata_q  <= 1'b0;
          end else begin
            m_wdata_q <= d_bit;
          end
        end
        ST_RDATA: begin
          if (s_rvalid && d_last) begin
            d_rdata_q <= d_word_next;
            b_req_q   <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          d_ready_q <= 1'b1;
          m_mode_q  <= 1'b0;
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
          d_err_q   <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign d_ready  = d_ready_q;
  assign d_rdata  = d_rdata_q;
  assign b_req    = b_req_q;
  assign m_mode   = m_mode_q;
  assign m_wvalid = m_wvalid_q;
  assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_serial_master_port.sv
// -----------------------------------------------------------------------------
// tb_serial_master_port
// Directed bench for serial_master_port: write, read with rvalid gaps,
// back-to-back transactions, reset mid-address, stray slave pulses and, when
// SERIAL_MASTER_PORT_TIMEOUT_EN is defined, acknowledge timeout behaviour.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_master_port;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_valid, d_mode;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_ready, d_err, b_req, b_grant;
  logic          m_mode, m_wvalid, m_wdata;
  logic          s_ack, s_rvalid, s_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_master_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .b_req(b_req), .b_grant(b_grant),
    .m_mode(m_mode), .m_wvalid(m_wvalid), .m_wdata(m_wdata),
    .s_ack(s_ack), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request in IDLE and confirm it is taken on the next edge.
  task automatic start(input string tag, input logic mode, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit hold);
    check({tag, "/idle"}, {d_ready, b_req}, 2'b10);
    d_valid = 1'b1; d_mode = mode; d_addr = addr; d_wdata = wdata;
    tick();
    check({tag, "/accepted"}, {d_ready, b_req}, 2'b01);
    if (!hold) begin
      // Scramble the request inputs: they must not be re-sampled.
      d_valid = 1'b0; d_mode = ~mode; d_addr = ~addr; d_wdata = ~wdata;
    end
  endtask

  // Run grant, address, acknowledge and data phases of an accepted request.
  task automatic finish(input string tag, input logic mode, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int gdly, input int adly,
                        input logic [DW-1:0] gaps, input bit stray);
    logic [AW-1:0] abits;
    logic [DW-1:0] dbits;
    int bad, g, extra;
    b_grant = 1'b0;
    for (int i = 0; i < gdly; i++) tick();
    check({tag, "/req_wait"}, {b_req, m_wvalid}, 2'b10);
    b_grant = 1'b1; tick(); b_grant = 1'b0;  // grant sampled; drop is ignored
    g = cyc; bad = 0; abits = '0;
    for (int i = 0; i < AW; i++) begin
      if (m_wvalid !== 1'b1 || m_mode !== mode) bad++;
      abits[i] = m_wdata;
      if (stray) begin s_ack = (i == 3); s_rvalid = (i == 5); s_rdata = 1'b1; end
      tick();
    end
    s_ack = 1'b0; s_rvalid = 1'b0; s_rdata = 1'b0;
    check({tag, "/addr_valid_mode"}, bad, 0);
    check({tag, "/addr_bits"}, abits, addr);
    check({tag, "/ack_wait"}, {m_wvalid, b_req}, 2'b01);
    for (int i = 0; i < adly; i++) tick();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    extra = 0; bad = 0;
    if (mode) begin
      dbits = '0;
      for (int i = 0; i < DW; i++) begin
        if (m_wvalid !== 1'b1) bad++;
        dbits[i] = m_wdata;
        tick();
      end
      check({tag, "/wdata_valid"}, bad, 0);
      check({tag, "/wdata_bits"}, dbits, data);
    end else begin
      for (int k = 0; k < DW; k++) begin
        s_rvalid = 1'b1; s_rdata = data[k];
        if (m_wvalid !== 1'b0) bad++;
        tick();
        if (gaps[k]) begin
          s_rvalid = 1'b0; s_rdata = ~data[k];
          if (m_wvalid !== 1'b0) bad++;
          tick();
          extra++;
        end
      end
      s_rvalid = 1'b0; s_rdata = 1'b0;
      check({tag, "/rdata_no_wvalid"}, bad, 0);
    end
    // DONE cycle
    check({tag, "/done"}, {d_ready, b_req, m_wvalid, d_err, m_mode}, {4'b0000, mode});
    if (!mode) check({tag, "/rdata"}, d_rdata, data);
    tick();
    check({tag, "/ready"}, d_ready, 1'b1);
    check({tag, "/latency"}, cyc - g, AW + adly + DW + extra + 2);
    $display("txn %s mode=%0d addr=%h data=%h latency=%0d", tag, mode, addr, data, cyc - g);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    rst = 1'b1; d_valid = 1'b0; d_mode = 1'b0; d_addr = '0; d_wdata = '0;
    b_grant = 1'b0; s_ack = 1'b0; s_rvalid = 1'b0; s_rdata = 1'b0;
    tick(); tick();
    check("reset/outputs", {d_ready, d_err, b_req, m_mode, m_wvalid, m_wdata}, 6'b100000);
    check("reset/rdata", d_rdata, 8'h00);
    rst = 1'b0; tick();

    // Stray slave pulses while idle.
    s_ack = 1'b1; s_rvalid = 1'b1; s_rdata = 1'b1; tick(); tick();
    s_ack = 1'b0; s_rvalid = 1'b0; s_rdata = 1'b0;
    check("stray_idle", {d_ready, b_req, m_wvalid, d_err}, 4'b1000);

    // Write 8801/A5, grant after 3 cycles, ack after 2, strays during ADDR.
    start("wr", 1'b1, 16'h8801, 8'hA5, 1'b0);
    finish("wr", 1'b1, 16'h8801, 8'hA5, 3, 2, 8'h00, 1'b1);

    // Back-to-back: write 11 then read F0 with d_valid held high.
    start("b2b_wr", 1'b1, 16'h0042, 8'h11, 1'b1);
    d_mode = 1'b0; d_addr = 16'h0043; d_wdata = 8'hEE;
    finish("b2b_wr", 1'b1, 16'h0042, 8'h11, 0, 0, 8'h00, 1'b0);
    start("b2b_rd", 1'b0, 16'h0043, 8'hEE, 1'b0);
    finish("b2b_rd", 1'b0, 16'h0043, 8'hF0, 1, 1, 8'h00, 1'b0);

    // Reset during address bit 7 of a write.
    start("rst_mid", 1'b1, 16'hBEEF, 8'h77, 1'b0);
    b_grant = 1'b1; tick(); b_grant = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("rst_mid/addr_bit7", {m_wvalid, m_wdata, m_mode}, 3'b111);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid/outputs", {d_ready, d_err, b_req, m_mode, m_wvalid, m_wdata}, 6'b100000);
    check("rst_mid/rdata", d_rdata, 8'h00);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (d_err !== 1'b0 || b_req !== 1'b0) bad++;
      tick();
    end
    check("rst_mid/quiet", bad, 0);
    start("rst_rd", 1'b0, 16'h1234, 8'h00, 1'b0);
    finish("rst_rd", 1'b0, 16'h1234, 8'h5A, 1, 3, 8'h00, 1'b1);

    // Read 8801 returning 3C with rvalid gaps after bits 2 and 5.
    start("rd", 1'b0, 16'h8801, 8'h00, 1'b0);
    finish("rd", 1'b0, 16'h8801, 8'h3C, 0, 1, 8'h24, 1'b0);

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
    // No acknowledge: abort after TMO cycles, d_rdata held.
    start("tmo", 1'b0, 16'h00AA, 8'h00, 1'b0);
    b_grant = 1'b1; tick(); b_grant = 1'b0;
    for (int i = 0; i < AW; i++) tick();
    for (int i = 0; i < TMO; i++) tick();
    check("tmo/done", {d_err, b_req, m_wvalid, d_ready}, 4'b1000);
    check("tmo/rdata_held", d_rdata, 8'h3C);
    tick();
    check("tmo/idle", {d_err, d_ready}, 2'b01);
    $display("txn tmo mode=0 addr=00aa aborted");
    // Acknowledge on the expiry cycle wins.
    start("tmo_ack", 1'b0, 16'h0055, 8'h00, 1'b0);
    finish("tmo_ack", 1'b0, 16'h0055, 8'h96, 0, TMO - 1, 8'h00, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
